mem_stage: RTL and testbench



---
 rtl/mem_stage_pkg.sv | 41 ++++
 rtl/mem_stage_if.sv | 35 +++
 rtl/mem_stage_load_ext.sv | 29 ++
 rtl/mem_stage.sv | 95 +++++++++
 tb/tb_mem_stage.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types and widths for the memory-access pipeline stage.
// Field order in every struct matches the bit layout the neighbouring stages expect.
package mem_stage_pkg;

    localparam int EX_RF_LEN   = 40;
    localparam int MEM_WB_LEN  = 70;
    localparam int MEM_RF_LEN  = 39;
    localparam int EXCEPT_LEN  = 82;
    localparam int EXC_PRESENT = 2;

    typedef struct packed {
        logic        csr_re;
        logic        res_from_mem;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] alu_result;
    } ex_rf_t;

    typedef struct packed {
        logic ld_w;
        logic ld_b;
        logic ld_h;
        logic ld_bu;
        logic ld_hu;
    } ld_inst_t;

    typedef struct packed {
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] final_result;
        logic [31:0] pc;
    } mem_wb_t;

    typedef struct packed {
        logic        csr_re;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] final_result;
    } mem_rf_t;

endpackage

// File: rtl/mem_stage_if.sv
// Handshake and payload bundle around the memory stage.
// master = surrounding pipeline (EX, SRAM, WB); slave = the memory stage itself.
interface mem_stage_if;
    import mem_stage_pkg::*;

    logic                  EX_MEM_valid;
    logic                  MEM_allowin;
    ex_rf_t                EX_rf_bus;
    logic [31:0]           EX_pc;
    ld_inst_t              EX_mem_ld_inst;
    logic [EXCEPT_LEN-1:0] EX_except_bus;
    logic [31:0]           data_sram_rdata;
    logic                  WB_allowin;
    logic                  WB_EXC_signal;
    logic                  MEM_WB_valid;
    mem_wb_t               MEM_WB_bus;
    logic [EXCEPT_LEN-1:0] MEM_except_bus;
    mem_rf_t               MEM_rf_bus;
    logic                  MEM_EXC_signal;

    modport master (
        output EX_MEM_valid, EX_rf_bus, EX_pc, EX_mem_ld_inst, EX_except_bus,
               data_sram_rdata, WB_allowin, WB_EXC_signal,
        input  MEM_allowin, MEM_WB_valid, MEM_WB_bus, MEM_except_bus,
               MEM_rf_bus, MEM_EXC_signal
    );

    modport slave (
        input  EX_MEM_valid, EX_rf_bus, EX_pc, EX_mem_ld_inst, EX_except_bus,
               data_sram_rdata, WB_allowin, WB_EXC_signal,
        output MEM_allowin, MEM_WB_valid, MEM_WB_bus, MEM_except_bus,
               MEM_rf_bus, MEM_EXC_signal
    );

endinterface

// File: rtl/mem_stage_load_ext.sv
// Combinational load alignment: picks the byte/halfword at the address offset and extends it.
// Halfword selection uses offset[1] only; an absent load type passes the word through.
module load_ext
    import mem_stage_pkg::*;
(
    input  ld_inst_t    ld_inst,
    input  logic [1:0]  offset,
    input  logic [31:0] rdata,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[{offset, 3'b000} +: 8];
        half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
        data     = rdata;
        if (ld_inst.ld_b)
            data = {{24{byte_sel[7]}}, byte_sel};
        else if (ld_inst.ld_bu)
            data = {24'b0, byte_sel};
        else if (ld_inst.ld_h)
            data = {{16{half_sel[15]}}, half_sel};
        else if (ld_inst.ld_hu)
            data = {16'b0, half_sel};
    end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: registers the EX payload, captures SRAM read data on the first occupied cycle
// and holds it across WB stalls, then forms the write-back/forwarding result. Always ready to go.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic clk,
    input  logic reset,
    mem_stage_if.slave bus
);

    logic                  mem_valid;
    ex_rf_t                rf_q;
    logic [31:0]           pc_q;
    ld_inst_t              ld_q;
    logic [EXCEPT_LEN-1:0] exc_q;
    logic                  rd_held;
    logic [31:0]           rd_hold;

    logic                  allowin;
    logic                  load_payload;
    logic [31:0]           rdata_eff;
    logic [31:0]           ld_data;
    logic [31:0]           final_result;

    assign allowin      = ~mem_valid | bus.WB_allowin;
    assign load_payload = bus.EX_MEM_valid & allowin;

    // A flush wins over a new acceptance; the payload still loads but is dead.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            mem_valid <= 1'b0;
        else if (bus.WB_EXC_signal)
            mem_valid <= 1'b0;
        else if (allowin)
            mem_valid <= bus.EX_MEM_valid;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rf_q  <= '0;
            pc_q  <= '0;
            ld_q  <= '0;
            exc_q <= '0;
        end else if (load_payload) begin
            rf_q  <= bus.EX_rf_bus;
            pc_q  <= bus.EX_pc;
            ld_q  <= bus.EX_mem_ld_inst;
            exc_q <= bus.EX_except_bus;
        end
    end

    // SRAM output is only guaranteed in the first MEM cycle, so snapshot it for later stalls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_held <= 1'b0;
            rd_hold <= '0;
        end else if (load_payload) begin
            rd_held <= 1'b0;
        end else if (mem_valid && !rd_held) begin
            rd_held <= 1'b1;
            rd_hold <= bus.data_sram_rdata;
        end
    end

    assign rdata_eff = rd_held ? rd_hold : bus.data_sram_rdata;

    load_ext u_load_ext (
        .ld_inst (ld_q),
        .offset  (rf_q.alu_result[1:0]),
        .rdata   (rdata_eff),
        .data    (ld_data)
    );

    assign final_result = rf_q.res_from_mem ? ld_data : rf_q.alu_result;

    always_comb begin
        bus.MEM_WB_bus              = '0;
        bus.MEM_WB_bus.rf_we        = rf_q.rf_we & mem_valid;
        bus.MEM_WB_bus.rf_waddr     = rf_q.rf_waddr;
        bus.MEM_WB_bus.final_result = final_result;
        bus.MEM_WB_bus.pc           = pc_q;

        bus.MEM_rf_bus              = '0;
        bus.MEM_rf_bus.csr_re       = rf_q.csr_re & mem_valid;
        bus.MEM_rf_bus.rf_we        = rf_q.rf_we & mem_valid;
        bus.MEM_rf_bus.rf_waddr     = rf_q.rf_waddr;
        bus.MEM_rf_bus.final_result = final_result;
    end

    assign bus.MEM_allowin    = allowin;
    assign bus.MEM_WB_valid   = mem_valid;
    assign bus.MEM_except_bus = exc_q;
    assign bus.MEM_EXC_signal = mem_valid & exc_q[EXC_PRESENT];

endmodule

// File: tb/tb_mem_stage.sv
// Directed scenarios followed by random traffic, all checked against a behavioural slot model.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_stage_if bus_if();

    mem_stage u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model: one slot holding the instruction plus the first-cycle SRAM word once seen.
    logic        m_valid;
    logic        m_have;
    logic [31:0] m_data;
    ex_rf_t      m_rf;
    logic [31:0] m_pc;
    ld_inst_t    m_ld;
    logic [81:0] m_exc;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_load(input ex_rf_t rf, input ld_inst_t ld, input logic [31:0] rdata);
        int unsigned off;
        logic [31:0] b, h;
        off = int'(rf.alu_result[1:0]);
        b = (rdata >> (8 * off)) & 32'hFF;
        h = (rdata >> (16 * (off / 2))) & 32'hFFFF;
        if (!rf.res_from_mem) return rf.alu_result;
        if (ld.ld_w)  return rdata;
        if (ld.ld_b)  return (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
        if (ld.ld_bu) return b;
        if (ld.ld_h)  return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
        if (ld.ld_hu) return h;
        return rdata;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0; m_have = 1'b0; m_data = '0;
        m_rf = '0; m_pc = '0; m_ld = '0; m_exc = '0;
    endtask

    task automatic check_outputs();
        logic [31:0] res;
        res = ref_load(m_rf, m_ld, m_have ? m_data : bus_if.data_sram_rdata);
        check_eq("allowin", bus_if.MEM_allowin, !m_valid || bus_if.WB_allowin);
        check_eq("wb_valid", bus_if.MEM_WB_valid, m_valid);
        check_eq("wb_bus", bus_if.MEM_WB_bus, {m_rf.rf_we & m_valid, m_rf.rf_waddr, res, m_pc});
        check_eq("rf_bus", bus_if.MEM_rf_bus,
                 {m_rf.csr_re & m_valid, m_rf.rf_we & m_valid, m_rf.rf_waddr, res});
        check_eq("exc_bus", bus_if.MEM_except_bus, m_exc);
        check_eq("exc_sig", bus_if.MEM_EXC_signal, m_valid & m_exc[2]);
    endtask

    task automatic advance();
        logic accept;
        @(posedge clk);
        if (reset) begin
            model_reset();
        end else begin
            accept = bus_if.EX_MEM_valid && (!m_valid || bus_if.WB_allowin);
            if (accept) begin
                m_rf = bus_if.EX_rf_bus; m_pc = bus_if.EX_pc;
                m_ld = bus_if.EX_mem_ld_inst; m_exc = bus_if.EX_except_bus;
                m_have = 1'b0;
            end else if (m_valid && !m_have) begin
                m_have = 1'b1;
                m_data = bus_if.data_sram_rdata;
            end
            if (bus_if.WB_EXC_signal) m_valid = 1'b0;
            else if (!m_valid || bus_if.WB_allowin) m_valid = bus_if.EX_MEM_valid;
        end
        #1;
    endtask

    task automatic drive(input logic v, input ex_rf_t rf, input logic [31:0] pc, input ld_inst_t ld,
                         input logic [81:0] exc, input logic [31:0] rdata, input logic wba, input logic wbx);
        bus_if.EX_MEM_valid    = v;
        bus_if.EX_rf_bus       = rf;
        bus_if.EX_pc           = pc;
        bus_if.EX_mem_ld_inst  = ld;
        bus_if.EX_except_bus   = exc;
        bus_if.data_sram_rdata = rdata;
        bus_if.WB_allowin      = wba;
        bus_if.WB_EXC_signal   = wbx;
    endtask

    task automatic settle();
        #3;
        check_outputs();
    endtask

    function automatic ex_rf_t mk_rf(input logic mem, input logic we, input logic [4:0] wa, input logic [31:0] alu);
        ex_rf_t r;
        r = '0;
        r.res_from_mem = mem; r.rf_we = we; r.rf_waddr = wa; r.alu_result = alu;
        return r;
    endfunction

    localparam ld_inst_t LD_W  = 5'b10000;
    localparam ld_inst_t LD_B  = 5'b01000;
    localparam ld_inst_t LD_H  = 5'b00100;
    localparam ld_inst_t LD_BU = 5'b00010;
    localparam ld_inst_t LD_HU = 5'b00001;

    initial begin
        logic [95:0] rnd;
        logic [81:0] exc_v;
        logic [4:0]  one;
        ex_rf_t      rf;
        ld_inst_t    ld;

        model_reset();
        reset = 1'b1;
        drive(1'b0, '0, '0, '0, '0, 32'hA5A5_A5A5, 1'b1, 1'b0);
        #3;
        check_outputs();
        check_eq("rst_allowin", bus_if.MEM_allowin, 1'b1);
        advance();
        reset = 1'b0;

        // ALU pass-through
        drive(1'b1, mk_rf(1'b0, 1'b1, 5'd5, 32'h1234_5678), 32'h100, '0, '0, 32'h0, 1'b1, 1'b0);
        settle(); advance();
        drive(1'b0, '0, '0, '0, '0, 32'h0, 1'b1, 1'b0);
        settle();
        check_eq("alu_res", bus_if.MEM_WB_bus.final_result, 32'h1234_5678);
        check_eq("alu_we", bus_if.MEM_rf_bus.rf_we, 1'b1);
        check_eq("alu_wa", bus_if.MEM_rf_bus.rf_waddr, 5'd5);
        advance();

        // Back-to-back loads; each cycle returns rdata for the load already in MEM
        drive(1'b1, mk_rf(1'b1, 1'b1, 5'd1, 32'h1003), 32'h200, LD_B, '0, 32'h0, 1'b1, 1'b0);
        settle(); advance();
        drive(1'b1, mk_rf(1'b1, 1'b1, 5'd2, 32'h1003), 32'h204, LD_BU, '0, 32'h80AA_BBCC, 1'b1, 1'b0);
        settle(); check_eq("ld_b", bus_if.MEM_WB_bus.final_result, 32'hFFFF_FF80); advance();
        drive(1'b1, mk_rf(1'b1, 1'b1, 5'd3, 32'h1002), 32'h208, LD_HU, '0, 32'h80AA_BBCC, 1'b1, 1'b0);
        settle(); check_eq("ld_bu", bus_if.MEM_WB_bus.final_result, 32'h0000_0080); advance();
        drive(1'b1, mk_rf(1'b1, 1'b1, 5'd4, 32'h1000), 32'h20C, LD_H, '0, 32'h80AA_BBCC, 1'b1, 1'b0);
        settle(); check_eq("ld_hu", bus_if.MEM_WB_bus.final_result, 32'h0000_80AA); advance();
        drive(1'b0, '0, '0, '0, '0, 32'h80AA_BBCC, 1'b1, 1'b0);
        settle(); check_eq("ld_h", bus_if.MEM_WB_bus.final_result, 32'hFFFF_BBCC); advance();

        // Stalled ld.w keeps its first-cycle data; the next load gets fresh data
        drive(1'b1, mk_rf(1'b1, 1'b1, 5'd6, 32'h2000), 32'h300, LD_W, '0, 32'h0, 1'b1, 1'b0);
        settle(); advance();
        drive(1'b1, mk_rf(1'b1, 1'b1, 5'd7, 32'h2004), 32'h304, LD_W, '0, 32'h1111_1111, 1'b0, 1'b0);
        settle(); check_eq("stall0", bus_if.MEM_WB_bus.final_result, 32'h1111_1111); advance();
        for (int i = 0; i < 2; i++) begin
            bus_if.data_sram_rdata = 32'hDEAD_BEEF;
            settle(); check_eq("stall_hold", bus_if.MEM_WB_bus.final_result, 32'h1111_1111); advance();
        end
        bus_if.WB_allowin = 1'b1;
        settle(); check_eq("handoff", bus_if.MEM_WB_bus.final_result, 32'h1111_1111); advance();
        drive(1'b0, '0, '0, '0, '0, 32'h2222_2222, 1'b1, 1'b0);
        settle(); check_eq("fresh", bus_if.MEM_WB_bus.final_result, 32'h2222_2222); advance();

        // Flush
        drive(1'b1, mk_rf(1'b0, 1'b1, 5'd8, 32'h55), 32'h400, '0, '0, 32'h0, 1'b1, 1'b0);
        settle(); advance();
        drive(1'b0, '0, '0, '0, '0, 32'h0, 1'b1, 1'b1);
        settle(); check_eq("pre_flush", bus_if.MEM_WB_valid, 1'b1); advance();
        drive(1'b0, '0, '0, '0, '0, 32'h0, 1'b1, 1'b0);
        settle();
        check_eq("flush_vld", bus_if.MEM_WB_valid, 1'b0);
        check_eq("flush_we", bus_if.MEM_rf_bus.rf_we, 1'b0);
        check_eq("flush_exc", bus_if.MEM_EXC_signal, 1'b0);
        advance();

        // Exception carried through
        exc_v = 82'h2_ABCD_0123_4567_89AB_CDE4;
        drive(1'b1, mk_rf(1'b0, 1'b1, 5'd9, 32'h77), 32'h500, '0, exc_v, 32'h0, 1'b1, 1'b0);
        settle(); advance();
        drive(1'b0, '0, '0, '0, '0, 32'h0, 1'b0, 1'b0);
        settle();
        check_eq("exc_sig1", bus_if.MEM_EXC_signal, 1'b1);
        check_eq("exc_val", bus_if.MEM_except_bus, exc_v);
        check_eq("exc_we", bus_if.MEM_WB_bus.rf_we, 1'b1);

        // Reset mid-stall
        #2 reset = 1'b1;
        #1;
        check_eq("mrst_vld", bus_if.MEM_WB_valid, 1'b0);
        check_eq("mrst_wb", bus_if.MEM_WB_bus, '0);
        check_eq("mrst_rf", bus_if.MEM_rf_bus, '0);
        check_eq("mrst_exc", bus_if.MEM_except_bus, '0);
        check_eq("mrst_sig", bus_if.MEM_EXC_signal, 1'b0);
        check_eq("mrst_alw", bus_if.MEM_allowin, 1'b1);
        model_reset();
        advance();
        reset = 1'b0;
        drive(1'b1, mk_rf(1'b0, 1'b1, 5'd10, 32'hCAFE_F00D), 32'h600, '0, '0, 32'h0, 1'b1, 1'b0);
        settle(); advance();
        drive(1'b0, '0, '0, '0, '0, 32'h0, 1'b1, 1'b0);
        settle(); check_eq("post_rst", bus_if.MEM_WB_bus.final_result, 32'hCAFE_F00D); advance();

        // Random traffic
        one = 5'b00001;
        for (int c = 0; c < 1500; c++) begin
            rnd   = {$urandom, $urandom, $urandom};
            exc_v = rnd[81:0];
            rf    = ex_rf_t'({$urandom, $urandom});
            ld    = rf.res_from_mem ? ld_inst_t'(one << $urandom_range(0, 4)) : ld_inst_t'(5'b0);
            drive($urandom_range(0, 3) != 0, rf, $urandom, ld, exc_v, $urandom,
                  $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);
            settle();
            advance();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
